// File: rtl/adder_sum_stage_pkg.sv
// adder_sum_stage_pkg: shared widths, skid state encodings and flag layout for the adder sum stage
package adder_sum_stage_pkg;
  localparam int LEN_DATA = 32;
  localparam int TAG_W_DEF = 4;
  localparam int FLAG_W = 4;
  typedef enum logic [1:0] {
    ADD_SUM_EMPTY = 2'd0,
    ADD_SUM_ONE   = 2'd1,
    ADD_SUM_TWO   = 2'd2
  } skid_state_e;
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;
endpackage

// File: rtl/adder_sum_stage_result_skid_buf.sv
// result_skid_buf: generic 2-entry valid/ready skid buffer with registered in_ready
module result_skid_buf
  import adder_sum_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state, state_nx;
  logic [W-1:0] skid_data;
  logic in_xfer, out_xfer, load_out, load_skid, pop_skid;
  always_comb begin
    in_xfer = in_valid & in_ready;
    out_xfer = out_valid & out_ready;
    state_nx = state;
    load_out = 1'b0;
    load_skid = 1'b0;
    pop_skid = 1'b0;
    case (state)
      ADD_SUM_EMPTY: begin
        state_nx = in_xfer ? ADD_SUM_ONE : ADD_SUM_EMPTY;
        load_out = in_xfer;
      end
      ADD_SUM_ONE: begin
        state_nx = in_xfer ? (out_xfer ? ADD_SUM_ONE : ADD_SUM_TWO) : (out_xfer ? ADD_SUM_EMPTY : ADD_SUM_ONE);
        load_out = in_xfer & out_xfer;
        load_skid = in_xfer & ~out_xfer;
      end
      ADD_SUM_TWO: begin
        state_nx = out_xfer ? ADD_SUM_ONE : ADD_SUM_TWO;
        pop_skid = out_xfer;
      end
      default: state_nx = ADD_SUM_EMPTY;
    endcase
  end
  // in_ready follows the next state so it never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ADD_SUM_EMPTY;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != ADD_SUM_TWO;
      out_valid <= state_nx != ADD_SUM_EMPTY;
      if (load_out) out_data <= in_data;
      else if (pop_skid) out_data <= skid_data;
      if (load_skid) skid_data <= in_data;
    end
  end
endmodule

// File: rtl/adder_sum_stage.sv
// adder_sum_stage: forms sum and NZCV flags from prefix carries and half sums, then registers them
module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int N = LEN_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       g_prefix,
  input  logic [N:0]       p_half,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z,
  output logic [TAG_W-1:0] out_tag
);
  localparam int W = N + FLAG_W + TAG_W;
  logic [N-1:0] sum_c;
  flags_t flags;
  logic [W-1:0] pay_in, pay_out;
  logic unused_p0;
  always_comb begin
    sum_c = p_half[N:1] ^ g_prefix[N-1:0];
    flags.c = g_prefix[N];
    flags.v = g_prefix[N] ^ g_prefix[N-1];
    flags.n = sum_c[N-1];
    flags.z = ~|sum_c;
  end
  assign unused_p0 = p_half[0];
  assign pay_in = {in_tag, flags, sum_c};
  result_skid_buf #(.W(W)) u_buf (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(pay_out)
  );
  assign {out_tag, flag_c, flag_v, flag_n, flag_z, sum} = pay_out;
endmodule

// File: tb/tb_adder_sum_stage.sv
// tb_adder_sum_stage: scoreboard bench driving a golden carry model into the sum stage
module tb_adder_sum_stage;
  import adder_sum_stage_pkg::*;
  localparam int N = LEN_DATA;
  localparam int TW = 4;
  typedef logic [TW+4+N-1:0] res_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, flag_c, flag_v, flag_n, flag_z;
  logic [N:0] g_prefix = '0, p_half = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [N-1:0] sum;
  res_t obs, cur_exp, held;
  res_t q[$];
  logic held_v = 1'b0, lat_chk = 1'b0, rand_ready = 1'b0;
  int errors = 0, checks = 0, n_out = 0;
  always #5 clk = ~clk;
  adder_sum_stage #(.TAG_W(TW), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_prefix(g_prefix), .p_half(p_half), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z), .out_tag(out_tag)
  );
  assign obs = {out_tag, flag_c, flag_v, flag_n, flag_z, sum};
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic res_t model(input logic [N-1:0] a, b, input logic cin, input logic [TW-1:0] t);
    logic [N:0] s;
    logic v;
    s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    return {t, s[N], v, s[N-1], s[N-1:0] == '0, s[N-1:0]};
  endfunction
  task automatic set_op(input logic [N-1:0] a, b, input logic cin, input logic [TW-1:0] t);
    logic [N:0] g;
    g[0] = cin;
    for (int k = 0; k < N; k++) g[k+1] = (a[k] & b[k]) | ((a[k] ^ b[k]) & g[k]);
    g_prefix = g;
    p_half = {a ^ b, 1'($urandom)};
    in_tag = t;
    cur_exp = model(a, b, cin, t);
  endtask
  task automatic tick();
    if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
    if (held_v) check("hold", {out_valid, obs}, {1'b1, held});
    held_v = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 64'(q.size()), 1);
      else check("result", obs, q.pop_front());
      n_out++;
    end else if (out_valid) begin
      held = obs;
      held_v = 1'b1;
    end
    if (lat_chk) check("latency", out_valid, 1);
    lat_chk = in_valid && in_ready;
    if (lat_chk) q.push_back(cur_exp);
    @(negedge clk);
  endtask
  task automatic send(input logic [N-1:0] a, b, input logic cin, input logic [TW-1:0] t, output int cyc);
    logic acc;
    set_op(a, b, cin, t);
    in_valid = 1'b1;
    cyc = 0;
    do begin
      acc = in_ready;
      tick();
      cyc++;
    end while (!acc && cyc < 200);
    check("accept", acc, 1);
  endtask
  task automatic drain();
    int c;
    in_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while ((q.size() != 0 || out_valid) && c < 100) begin
      tick();
      c++;
    end
    check("drain", {out_valid, 32'(q.size())}, 0);
  endtask
  initial begin
    int cyc, n0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_payload", obs, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'h1, 1'b0, 4'h5, cyc);
    check("t1_sum", sum, 32'h80000000);
    check("t1_cvnz", {flag_c, flag_v, flag_n, flag_z}, 4'b0110);
    check("t1_tag", out_tag, 4'h5);
    send(32'hFFFFFFFF, 32'h1, 1'b0, 4'h6, cyc);
    check("t2a_cvnz", {flag_c, flag_v, flag_n, flag_z}, 4'b1001);
    send(32'h80000000, 32'h80000000, 1'b0, 4'h7, cyc);
    check("t2b_cvnz", {sum == '0, flag_c, flag_v, flag_z}, 4'b1111);
    drain();
    n0 = n_out;
    for (int t = 0; t < 8; t++) begin
      send($urandom, $urandom, 1'($urandom), 4'(t), cyc);
      check("b2b_cycles", cyc, 1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_outputs", n_out - n0, 8);
    drain();
    out_ready = 1'b0;
    send(32'd10, 32'd20, 1'b0, 4'h1, cyc);
    send(32'hFFFF0000, 32'h00010000, 1'b1, 4'h2, cyc);
    check("t4_ready_low", in_ready, 0);
    set_op(32'h12345678, 32'h87654321, 1'b0, 4'h3);
    in_valid = 1'b1;
    repeat (3) begin
      check("t4_held_ready", in_ready, 0);
      check("t4_out_tag", out_tag, 4'h1);
      tick();
    end
    out_ready = 1'b1;
    send(32'h12345678, 32'h87654321, 1'b0, 4'h3, cyc);
    drain();
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      send($urandom, $urandom, 1'($urandom), 4'($urandom), cyc);
    end
    drain();
    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0, 4'hA, cyc);
    send(32'd3, 32'd4, 1'b0, 4'hB, cyc);
    in_valid = 1'b0;
    check("t6_full", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    rst = 1'b0;
    q.delete();
    held_v = 1'b0;
    lat_chk = 1'b0;
    @(negedge clk);
    check("t6_ready_after", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b1;
    send(32'd100, 32'd200, 1'b1, 4'hC, cyc);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
